// File: rtl/axi_clint_slave.sv
// Single-beat AXI4 slave exposing the machine-mode CLINT registers: msip, mtimecmp and mtime.
// mtime advances once every TICK_DIV clocks; the timer interrupt is a registered compare.
module axi_clint_slave #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        reset,
  // AW channel
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awsize,
  // W channel
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [63:0] s_wdata,
  input  logic [7:0]  s_wstrb,
  input  logic        s_wlast,
  // B channel
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  // AR channel
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arsize,
  // R channel
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [63:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  // Timer / interrupt outputs
  output logic [63:0] mtime,
  output logic        irq_m_timer,
  output logic        irq_m_software
);

  localparam logic [15:0] PrescMax   = 16'(TICK_DIV - 1);
  localparam logic [12:0] OffMsip    = 13'h0000;
  localparam logic [12:0] OffCmp     = 13'h0800;
  localparam logic [12:0] OffTime    = 13'h17FF;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespDecerr = 2'b11;

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        irq_timer_q, irq_timer_d;

  logic        aw_held_q, aw_held_d;
  logic [12:0] aw_off_q, aw_off_d;
  logic        w_held_q, w_held_d;
  logic [63:0] w_data_q, w_data_d;
  logic [7:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  logic        tick;
  logic        wr_commit;
  logic [12:0] ar_off;

  logic unused_ok;
  assign unused_ok = ^{s_awsize, s_arsize, s_wlast, s_awaddr[31:16], s_awaddr[2:0],
                       s_araddr[31:16], s_araddr[2:0]};

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

  assign tick      = (presc_q == PrescMax);
  assign wr_commit = aw_held_q && w_held_q && !bvalid_q;
  assign ar_off    = s_araddr[15:3];

  assign s_awready = !aw_held_q && !bvalid_q;
  assign s_wready  = !w_held_q && !bvalid_q;
  assign s_arready = !rvalid_q;

  always_comb begin
    presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    irq_timer_d = (mtime_q >= mtimecmp_q);

    aw_held_d = aw_held_q;
    aw_off_d  = aw_off_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (s_awvalid && s_awready) begin
      aw_held_d = 1'b1;
      aw_off_d  = s_awaddr[15:3];
    end
    if (s_wvalid && s_wready) begin
      w_held_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end

    // A software write to mtime overrides the increment computed above.
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RespOkay;
      case (aw_off_q)
        OffMsip: if (w_strb_q[0]) msip_d = w_data_q[0];
        OffCmp:  mtimecmp_d = byte_merge(mtimecmp_q, w_data_q, w_strb_q);
        OffTime: mtime_d = byte_merge(mtime_q, w_data_q, w_strb_q);
        default: bresp_d = RespDecerr;
      endcase
    end

    if (bvalid_q && s_bready) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    if (s_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rlast_d  = 1'b1;
      rresp_d  = RespOkay;
      case (ar_off)
        OffMsip: rdata_d = {63'd0, msip_q};
        OffCmp:  rdata_d = mtimecmp_q;
        OffTime: rdata_d = mtime_q;
        default: begin
          rdata_d = 64'd0;
          rresp_d = RespDecerr;
        end
      endcase
    end else if (rvalid_q && s_rready) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= 16'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      irq_timer_q <= 1'b0;
      aw_held_q   <= 1'b0;
      aw_off_q    <= 13'd0;
      w_held_q    <= 1'b0;
      w_data_q    <= 64'd0;
      w_strb_q    <= 8'd0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rdata_q     <= 64'd0;
      rresp_q     <= 2'b00;
      rlast_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      irq_timer_q <= irq_timer_d;
      aw_held_q   <= aw_held_d;
      aw_off_q    <= aw_off_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
    end
  end

  assign s_bvalid       = bvalid_q;
  assign s_bresp        = bresp_q;
  assign s_rvalid       = rvalid_q;
  assign s_rdata        = rdata_q;
  assign s_rresp        = rresp_q;
  assign s_rlast        = rlast_q;
  assign mtime          = mtime_q;
  assign irq_m_timer    = irq_timer_q;
  assign irq_m_software = msip_q;

endmodule

// File: doc/axi_clint_slave.md
AXI_CLINT_SLAVE -- requirements
Module: axi_clint_slave

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100, giving clk cycles per mtime increment (legal range 1..2^16).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have AW ports: s_awvalid in 1, s_awready out 1, s_awaddr in 32, s_awsize in 3 (ignored).
REQ-005 SHALL have W ports: s_wvalid in 1, s_wready out 1, s_wdata in 64, s_wstrb in 8, s_wlast in 1 (ignored).
REQ-006 SHALL have B ports: s_bvalid out 1, s_bready in 1, s_bresp out 2.
REQ-007 SHALL have AR ports: s_arvalid in 1, s_arready out 1, s_araddr in 32, s_arsize in 3 (ignored).
REQ-008 SHALL have R ports: s_rvalid out 1, s_rready in 1, s_rdata out 64, s_rresp out 2, s_rlast out 1.
REQ-009 SHALL have outputs mtime 64 (for rdtime), irq_m_timer 1, irq_m_software 1.

Function
REQ-010 SHALL be a single-beat AXI4 responder for the CPU's cacheless port; no bursts, every transfer is one 64-bit beat.
REQ-011 SHALL decode s_*addr[15:3]: 0x0000 msip, 0x4000 mtimecmp, 0xBFF8 mtime; any other offset is unmapped; addr[31:16] and addr[2:0] ignored.
REQ-012 SHALL implement msip as 1 bit in data bit 0 (strobe 0); bits 63:1 read 0 and ignore writes.
REQ-013 SHALL implement a prescaler counting 0..TICK_DIV-1; mtime increments by 1 (mod 2^64) in the cycle the prescaler equals TICK_DIV-1, then the prescaler returns to 0.
REQ-014 SHALL apply writes byte-wise per s_wstrb; strobe 0 bytes unchanged.
REQ-015 SHALL give a software write to mtime priority over the same-cycle increment; prescaler unaffected by mtime writes.
REQ-016 SHALL accept AW and W independently in either order: s_awready=1 while no AW held and s_bvalid=0; s_wready=1 while no W held and s_bvalid=0.
REQ-017 SHALL commit the write in the cycle after both AW and W are held, assert s_bvalid the same cycle, and hold s_bvalid, s_bresp stable until s_bready.
REQ-018 SHALL drop s_bvalid and release AW/W holds on s_bvalid&&s_bready; next AW/W acceptable the following cycle (max one write outstanding).
REQ-019 SHALL assert s_arready=1 while s_rvalid=0; on s_arvalid&&s_arready assert s_rvalid next cycle with s_rdata sampled from register state at the acceptance cycle, s_rlast=1.
REQ-020 SHALL hold s_rvalid, s_rdata, s_rresp, s_rlast stable until s_rready; s_arready=0 meanwhile.
REQ-021 SHALL return resp 2'b00 (OKAY) for mapped offsets, 2'b11 (DECERR) for unmapped; unmapped writes change nothing, unmapped reads return 0.
REQ-022 SHALL let read and write channels operate concurrently; same-cycle read of a register being committed returns the pre-write value.
REQ-023 SHALL register irq_m_timer = (mtime >= mtimecmp), unsigned 64-bit compare, one cycle after any change to either operand.
REQ-024 SHALL drive irq_m_software = msip directly from the register (visible the cycle after commit).
REQ-025 SHALL drive mtime output from the live register, no extra delay.

Reset
REQ-026 SHALL on reset: mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, irq_m_timer=0, irq_m_software=0.
REQ-027 SHALL on reset: s_bvalid=0, s_rvalid=0, s_rlast=0, s_bresp=0, s_rresp=0, s_rdata=0, AW/W holds cleared; s_awready, s_wready, s_arready=1 from the first cycle after reset.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation, issuing no response.

Verification
REQ-029 TICK_DIV=4, idle 40 cycles after reset -> mtime=10, irq_m_timer=0.
REQ-030 W (strb 0xFF, data 0x20) two cycles before AW to 0x4000, mtime counting -> single B OKAY; irq_m_timer rises one cycle after mtime reaches 0x20.
REQ-031 Write 0x1 to 0x0000, strb 0x01 -> irq_m_software=1; write with strb 0x00 -> stays 1; write 0x0 strb 0x01 -> 0.
REQ-032 Read 0xBFF8 with s_rready low 5 cycles -> s_rvalid, s_rdata, s_rlast stable throughout, s_arready=0; data = mtime at AR acceptance.
REQ-033 Write strb 0x0F data 0xDEADBEEF to 0xBFF8 on an increment cycle -> mtime[31:0]=0xDEADBEEF, upper bytes unchanged, increment lost.
REQ-034 Read/write 0x1000 -> DECERR, rdata=0, no state change; assert reset during held s_bvalid -> s_bvalid=0, mtimecmp=all ones.
